// File: rtl/vga_fill_scheduler.sv
// Rectangle-fill engine sharing the VGA adapter pixel write port with CPU stores.
// CPU stores always win the port; the fill cursor stalls in place while the CPU holds it.
module vga_fill_scheduler #(
  parameter int unsigned XW   = 9,
  parameter int unsigned YW   = 8,
  parameter int unsigned CW   = 8,
  parameter int unsigned XMAX = 320,
  parameter int unsigned YMAX = 240
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iCpuWrite,
  input  logic [XW-1:0] iCpuX,
  input  logic [YW-1:0] iCpuY,
  input  logic [CW-1:0] iCpuColor,
  input  logic          iStart,
  input  logic [XW-1:0] iX0,
  input  logic [YW-1:0] iY0,
  input  logic [XW-1:0] iX1,
  input  logic [YW-1:0] iY1,
  input  logic [CW-1:0] iColor,
  input  logic          iAbort,
  output logic [XW-1:0] oX,
  output logic [YW-1:0] oY,
  output logic [CW-1:0] oColor,
  output logic          oWriteEn,
  output logic          oBusy,
  output logic          oDone,
  output logic [16:0]   oPixCount
);

  localparam int unsigned PCW = 17;
  localparam logic [XW-1:0] X_LAST = XW'(XMAX - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(YMAX - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

  state_t         state_q, state_d;
  logic [XW-1:0]  cur_x_q, cur_x_d;
  logic [YW-1:0]  cur_y_q, cur_y_d;
  logic [XW-1:0]  x0_q, x0_d;
  logic [XW-1:0]  x1_q, x1_d;
  logic [YW-1:0]  y1_q, y1_d;
  logic [CW-1:0]  fill_color_q, fill_color_d;
  logic [XW-1:0]  out_x_q, out_x_d;
  logic [YW-1:0]  out_y_q, out_y_d;
  logic [CW-1:0]  out_color_q, out_color_d;
  logic           we_q, we_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [PCW-1:0] pix_cnt_q, pix_cnt_d;

  logic [XW-1:0]  x1_clip;
  logic [YW-1:0]  y1_clip;
  logic           last_pix;

  // Next-state and registered-output logic; CPU grant first, fill only on a free port.
  always_comb begin
    state_d      = state_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    x0_d         = x0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    fill_color_d = fill_color_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_color_d  = out_color_q;
    we_d         = 1'b0;
    pix_cnt_d    = pix_cnt_q;
    busy_d       = (state_q == ST_FILL);
    done_d       = (state_q == ST_DONE);

    x1_clip  = (32'(iX1) >= XMAX) ? X_LAST : iX1;
    y1_clip  = (32'(iY1) >= YMAX) ? Y_LAST : iY1;
    last_pix = (cur_x_q == x1_q) && (cur_y_q == y1_q);

    if (iCpuWrite) begin
      out_x_d     = iCpuX;
      out_y_d     = iCpuY;
      out_color_d = iCpuColor;
      we_d        = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          cur_x_d      = iX0;
          cur_y_d      = iY0;
          x0_d         = iX0;
          x1_d         = x1_clip;
          y1_d         = y1_clip;
          fill_color_d = iColor;
          pix_cnt_d    = '0;
          state_d      = ((iX0 > x1_clip) || (iY0 > y1_clip)) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (iAbort) begin
          state_d = ST_DONE;
        end else if (!iCpuWrite) begin
          out_x_d     = cur_x_q;
          out_y_d     = cur_y_q;
          out_color_d = fill_color_q;
          we_d        = 1'b1;
          pix_cnt_d   = pix_cnt_q + PCW'(1);
          if (last_pix) begin
            state_d = ST_DONE;
          end else if (cur_x_q < x1_q) begin
            cur_x_d = cur_x_q + XW'(1);
          end else begin
            cur_x_d = x0_q;
            cur_y_d = cur_y_q + YW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q      <= ST_IDLE;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      x0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      fill_color_q <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_color_q  <= '0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pix_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      fill_color_q <= fill_color_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_color_q  <= out_color_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pix_cnt_q    <= pix_cnt_d;
    end
  end

  assign oX        = out_x_q;
  assign oY        = out_y_q;
  assign oColor    = out_color_q;
  assign oWriteEn  = we_q;
  assign oBusy     = busy_q;
  assign oDone     = done_q;
  assign oPixCount = pix_cnt_q;

endmodule

// File: tb/tb_vga_fill_scheduler.sv
// Bench for vga_fill_scheduler: rectangle-index reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_vga_fill_scheduler;

  logic        iCLK, iRST;
  logic        iCpuWrite;
  logic [8:0]  iCpuX;
  logic [7:0]  iCpuY;
  logic [7:0]  iCpuColor;
  logic        iStart;
  logic [8:0]  iX0, iX1;
  logic [7:0]  iY0, iY1;
  logic [7:0]  iColor;
  logic        iAbort;
  logic [8:0]  oX;
  logic [7:0]  oY;
  logic [7:0]  oColor;
  logic        oWriteEn, oBusy, oDone;
  logic [16:0] oPixCount;

  vga_fill_scheduler dut (
    .iCLK(iCLK), .iRST(iRST), .iCpuWrite(iCpuWrite), .iCpuX(iCpuX), .iCpuY(iCpuY),
    .iCpuColor(iCpuColor), .iStart(iStart), .iX0(iX0), .iY0(iY0), .iX1(iX1), .iY1(iY1),
    .iColor(iColor), .iAbort(iAbort), .oX(oX), .oY(oY), .oColor(oColor),
    .oWriteEn(oWriteEn), .oBusy(oBusy), .oDone(oDone), .oPixCount(oPixCount)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit busy_seen = 0;
  int wx[$], wy[$], wc[$], wt[$];

  // Reference: a fill is a list of n = w*h pixels; pixel k sits at (x0 + k%w, y0 + k/w).
  int m_phase = 0;  // 0 idle, 1 filling, 2 finishing
  int m_k, m_n, m_w, m_x0, m_y0, m_col, x1c, y1c;
  int e_x = 0, e_y = 0, e_col = 0, e_we = 0, e_busy = 0, e_done = 0, e_cnt = 0;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  task automatic model_step();
    int nb, nd;
    if (iRST) begin
      m_phase = 0; e_x = 0; e_y = 0; e_col = 0; e_we = 0; e_busy = 0; e_done = 0; e_cnt = 0;
    end else begin
      nb = (m_phase == 1) ? 1 : 0;
      nd = (m_phase == 2) ? 1 : 0;
      e_we = 0;
      if (iCpuWrite) begin
        e_we = 1; e_x = int'(iCpuX); e_y = int'(iCpuY); e_col = int'(iCpuColor);
      end
      case (m_phase)
        0: if (iStart) begin
          x1c = (int'(iX1) > 319) ? 319 : int'(iX1);
          y1c = (int'(iY1) > 239) ? 239 : int'(iY1);
          e_cnt = 0;
          if (int'(iX0) > x1c || int'(iY0) > y1c) m_phase = 2;
          else begin
            m_x0 = int'(iX0); m_y0 = int'(iY0); m_col = int'(iColor);
            m_w = x1c - m_x0 + 1;
            m_n = m_w * (y1c - m_y0 + 1);
            m_k = 0;
            m_phase = 1;
          end
        end
        1: if (iAbort) m_phase = 2;
           else if (!iCpuWrite) begin
             e_x = m_x0 + m_k % m_w;
             e_y = m_y0 + m_k / m_w;
             e_col = m_col;
             e_we = 1;
             e_cnt++;
             m_k++;
             if (m_k == m_n) m_phase = 2;
           end
        default: m_phase = 0;
      endcase
      e_busy = nb;
      e_done = nd;
    end
  endtask

  initial forever begin
    @(posedge iCLK or posedge iRST);
    model_step();
  end

  // Every-cycle compare against the model, plus a log of observed writes.
  initial forever begin
    @(posedge iCLK);
    #1;
    cyc++;
    chk("oX", int'(oX), e_x);
    chk("oY", int'(oY), e_y);
    chk("oColor", int'(oColor), e_col);
    chk("oWriteEn", int'(oWriteEn), e_we);
    chk("oBusy", int'(oBusy), e_busy);
    chk("oDone", int'(oDone), e_done);
    chk("oPixCount", int'(oPixCount), e_cnt);
    if (oWriteEn) begin
      wx.push_back(int'(oX)); wy.push_back(int'(oY));
      wc.push_back(int'(oColor)); wt.push_back(cyc);
    end
    if (oDone) done_cnt++;
    if (oBusy) busy_seen = 1;
  end

  task automatic drive_idle();
    iCpuWrite = 1'b0; iStart = 1'b0; iAbort = 1'b0;
  endtask

  task automatic clear_log();
    wx.delete(); wy.delete(); wc.delete(); wt.delete();
  endtask

  task automatic set_rect(input int x0, input int y0, input int x1, input int y1, input int c);
    iX0 = 9'(x0); iY0 = 8'(y0); iX1 = 9'(x1); iY1 = 8'(y1); iColor = 8'(c);
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic start_fill(input int x0, input int y0, input int x1, input int y1, input int c);
    set_rect(x0, y0, x1, y1, c);
    iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      if (oDone) got = 1;
      else @(negedge iCLK);
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL %s: oDone not seen within %0d cycles", nm, budget);
    end
  endtask

  task automatic rand_rect();
    int x0, y0, x1, y1;
    x0 = int'($urandom_range(0, 335));
    y0 = int'($urandom_range(0, 250));
    x1 = x0 + int'($urandom_range(0, 14)) - 2;
    y1 = y0 + int'($urandom_range(0, 12)) - 2;
    if (x1 < 0) x1 = 0;
    if (x1 > 511) x1 = 511;
    if (y1 < 0) y1 = 0;
    if (y1 > 255) y1 = 255;
    set_rect(x0, y0, x1, y1, int'($urandom_range(0, 255)));
  endtask

  initial begin
    int d0, mxx, mxy, ex1[6], ey1[6];
    iRST = 1'b1;
    drive_idle();
    iCpuX = '0; iCpuY = '0; iCpuColor = '0;
    set_rect(0, 0, 0, 0, 0);
    repeat (3) @(negedge iCLK);
    chk("reset oX", int'(oX), 0);
    chk("reset oWriteEn", int'(oWriteEn), 0);
    chk("reset oBusy", int'(oBusy), 0);
    chk("reset oPixCount", int'(oPixCount), 0);
    iRST = 1'b0;
    @(negedge iCLK);

    // 2x3-wide rectangle in raster order
    clear_log(); d0 = done_cnt;
    start_fill(2, 3, 4, 4, 8'h1C);
    wait_done("t1 done", 50);
    @(negedge iCLK);
    ex1 = '{2, 3, 4, 2, 3, 4};
    ey1 = '{3, 3, 3, 4, 4, 4};
    chk("t1 writes", wx.size(), 6);
    if (wx.size() == 6)
      for (int i = 0; i < 6; i++) begin
        chk("t1 x", wx[i], ex1[i]);
        chk("t1 y", wy[i], ey1[i]);
        chk("t1 color", wc[i], 8'h1C);
      end
    chk("t1 pixcount", int'(oPixCount), 6);
    chk("t1 done pulses", done_cnt - d0, 1);

    // CPU store preempts the third fill cycle
    clear_log();
    start_fill(0, 0, 9, 0, 8'h33);
    @(negedge iCLK);
    @(negedge iCLK);
    iCpuWrite = 1'b1; iCpuX = 9'd100; iCpuY = 8'd50; iCpuColor = 8'hFF;
    @(negedge iCLK);
    iCpuWrite = 1'b0;
    wait_done("t2 done", 50);
    @(negedge iCLK);
    chk("t2 writes", wx.size(), 11);
    if (wx.size() == 11) begin
      chk("t2 cpu x", wx[2], 100);
      chk("t2 cpu y", wy[2], 50);
      chk("t2 cpu color", wc[2], 255);
      for (int i = 0; i < 11; i++)
        if (i != 2) chk("t2 fill x", wx[i], (i < 2) ? i : i - 1);
      chk("t2 no gaps", wt[10] - wt[0], 10);
    end
    chk("t2 pixcount", int'(oPixCount), 10);

    // Clipping at the right and bottom screen edges
    clear_log();
    start_fill(310, 230, 400, 255, 8'h0F);
    wait_done("t3 done", 300);
    @(negedge iCLK);
    chk("t3 writes", wx.size(), 100);
    mxx = 0; mxy = 0;
    foreach (wx[i]) begin
      if (wx[i] > mxx) mxx = wx[i];
      if (wy[i] > mxy) mxy = wy[i];
    end
    chk("t3 max x", mxx, 319);
    chk("t3 max y", mxy, 239);
    if (wx.size() > 0) begin
      chk("t3 last x", wx[wx.size()-1], 319);
      chk("t3 last y", wy[wy.size()-1], 239);
    end
    chk("t3 pixcount", int'(oPixCount), 100);

    // Empty rectangle: straight to done, no busy, no writes
    clear_log(); busy_seen = 0;
    start_fill(5, 5, 4, 9, 7);
    chk("t4 done after 1", int'(oDone), 0);
    @(negedge iCLK);
    chk("t4 done after 2", int'(oDone), 1);
    @(negedge iCLK);
    chk("t4 done after 3", int'(oDone), 0);
    chk("t4 writes", wx.size(), 0);
    chk("t4 busy seen", int'(busy_seen), 0);
    chk("t4 pixcount", int'(oPixCount), 0);

    // Full-screen fill aborted after 1000 pixels
    clear_log(); d0 = done_cnt;
    start_fill(0, 0, 319, 239, 8'h55);
    for (int i = 0; i < 2000 && wx.size() < 1000; i++) @(negedge iCLK);
    if (wx.size() < 1000) begin
      n_cmp++; n_err++;
      $display("FAIL t5 progress: got %0d writes expected 1000", wx.size());
    end
    iAbort = 1'b1;
    @(negedge iCLK);
    iAbort = 1'b0;
    wait_done("t5 done", 10);
    @(negedge iCLK);
    chk("t5 writes", wx.size(), 1000);
    chk("t5 pixcount", int'(oPixCount), 1000);
    chk("t5 done pulses", done_cnt - d0, 1);
    start_fill(1, 1, 1, 1, 9);
    wait_done("t5 restart", 10);
    @(negedge iCLK);
    chk("t5 restart pixcount", int'(oPixCount), 1);
    chk("t5 restart writes", wx.size(), 1001);

    // Asynchronous reset in the middle of a fill
    start_fill(0, 0, 319, 239, 8'h66);
    repeat (20) @(negedge iCLK);
    #2 iRST = 1'b1;
    #1;
    chk("t6 oWriteEn", int'(oWriteEn), 0);
    chk("t6 oBusy", int'(oBusy), 0);
    chk("t6 oPixCount", int'(oPixCount), 0);
    @(negedge iCLK);
    iRST = 1'b0;
    clear_log();
    repeat (10) @(negedge iCLK);
    chk("t6 quiet", wx.size(), 0);
    start_fill(0, 0, 1, 0, 1);
    wait_done("t6 restart", 10);
    @(negedge iCLK);
    chk("t6 restart writes", wx.size(), 2);

    // Randomized traffic: CPU stores, aborts, ignored starts, occasional reset
    for (int it = 0; it < 60; it++) begin
      bit got = 0;
      rand_rect();
      iStart = 1'b1;
      @(negedge iCLK);
      iStart = 1'b0;
      for (int c = 0; c < 1500 && !got; c++) begin
        if (oDone) got = 1;
        else begin
          iCpuWrite = ($urandom_range(0, 99) < 30);
          iCpuX = 9'($urandom_range(0, 511));
          iCpuY = 8'($urandom_range(0, 255));
          iCpuColor = 8'($urandom_range(0, 255));
          iAbort = ($urandom_range(0, 199) < 3);
          iStart = ($urandom_range(0, 99) < 8);
          if (iStart) rand_rect();
          if (it % 12 == 5 && c == 7) begin
            iRST = 1'b1;
            got = 1;
          end
          @(negedge iCLK);
        end
      end
      drive_idle();
      iRST = 1'b0;
      if (!got) begin
        n_cmp++; n_err++;
        $display("FAIL random iter %0d: oDone not seen", it);
      end
      @(negedge iCLK);
    end
    repeat (3) @(negedge iCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
